// File: rtl/table_rd_ctrl.sv
// table_rd_ctrl: credit-based read front end for table_top with a 2-deep response buffer.
// Define TABLE_RD_SCAN_EN to build in the full-table scan engine.
module table_rd_ctrl #(
  parameter int  TABLE_SIZE  = 32,
  parameter int  DATA_WIDTH  = 8,
  parameter int  OUTPUT_RATE = 2,
  localparam int IW          = $clog2(TABLE_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [OUTPUT_RATE*IW-1:0]       req_index,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [OUTPUT_RATE*DATA_WIDTH-1:0] rsp_data,
  output logic [OUTPUT_RATE-1:0]          rsp_mask,
  output logic                            rsp_last,
  input  logic                            scan_start,
  output logic                            scan_busy,
  output logic                            rd_en,
  output logic [OUTPUT_RATE*IW-1:0]       index_rd,
  input  logic [OUTPUT_RATE*DATA_WIDTH-1:0] data_rd
);
  localparam int DW = OUTPUT_RATE * DATA_WIDTH;

  logic [DW-1:0] buf_data [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    buf_count;
  logic          inflight;
  logic          pop;
  logic          credit;
  logic          issue;
  logic [2:0]    occ;

  assign rsp_valid = buf_count != 2'd0;
  assign rsp_data  = buf_data[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;
  // slots already owed: buffered beats plus the read still in the table
  assign occ       = 3'(buf_count) + 3'(inflight) - 3'(pop);
  assign credit    = !rst && (occ < 3'd2);
  assign rd_en     = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_count   <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        buf_data[wr_ptr] <= data_rd;
        wr_ptr           <= !wr_ptr;
      end
      if (pop)
        rd_ptr <= !rd_ptr;
      buf_count <= buf_count + 2'(inflight) - 2'(pop);
    end
  end

`ifdef TABLE_RD_SCAN_EN
  localparam int BW = $clog2(TABLE_SIZE + OUTPUT_RATE) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                    state;
  logic [BW-1:0]             base;
  logic [OUTPUT_RATE-1:0]    scan_mask;
  logic [OUTPUT_RATE*IW-1:0] scan_index;
  logic                      scan_fin;
  logic [OUTPUT_RATE-1:0]    iss_mask;
  logic                      iss_last;
  logic [OUTPUT_RATE-1:0]    fl_mask;
  logic                      fl_last;
  logic [OUTPUT_RATE-1:0]    buf_mask [2];
  logic [1:0]                buf_last;

  always_comb begin
    scan_mask  = '0;
    scan_index = '0;
    for (int j = 0; j < OUTPUT_RATE; j++) begin
      if (int'(base) + j < TABLE_SIZE) begin
        scan_mask[j]                 = 1'b1;
        scan_index[(j+1)*IW-1 -: IW] = IW'(int'(base) + j);
      end
    end
  end

  assign scan_fin  = int'(base) + OUTPUT_RATE >= TABLE_SIZE;
  assign req_ready = credit && (state == IDLE) && !scan_start;
  assign issue     = (state == SCAN) ? credit : (req_valid & req_ready);
  assign index_rd  = rst ? '0 : ((state == SCAN) ? scan_index : req_index);
  assign iss_mask  = (state == SCAN) ? scan_mask : '1;
  assign iss_last  = (state == SCAN) && scan_fin;
  assign rsp_mask  = buf_mask[rd_ptr];
  assign rsp_last  = buf_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      scan_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (scan_start) begin
          state     <= SCAN;
          base      <= '0;
          scan_busy <= 1'b1;
        end
        SCAN: if (issue) begin
          base <= base + BW'(OUTPUT_RATE);
          if (scan_fin)
            state <= DRAIN;
        end
        DRAIN: if (pop && rsp_last) begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tag rides one cycle behind the issue, alongside the table's read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_mask     <= '0;
      fl_last     <= 1'b0;
      buf_mask[0] <= '0;
      buf_mask[1] <= '0;
      buf_last    <= 2'b00;
    end else begin
      if (issue) begin
        fl_mask <= iss_mask;
        fl_last <= iss_last;
      end
      if (inflight) begin
        buf_mask[wr_ptr] <= fl_mask;
        buf_last[wr_ptr] <= fl_last;
      end
    end
  end
`else
  logic unused_scan_start;

  assign unused_scan_start = scan_start;
  assign req_ready         = credit;
  assign issue             = req_valid & req_ready;
  assign index_rd          = rst ? '0 : req_index;
  assign rsp_mask          = '1;
  assign rsp_last          = 1'b0;
  assign scan_busy         = 1'b0;
`endif

endmodule

// File: tb/tb_table_rd_ctrl.sv
// tb_table_rd_ctrl: scoreboard bench for table_rd_ctrl with a behavioural table.
// Scan tests compile in when TABLE_RD_SCAN_EN is defined.
module tb_table_rd_ctrl;
  localparam int TS = 32;
  localparam int IW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_index = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_mask;
  logic        rsp_last;
  logic        scan_start = 1'b0;
  logic        scan_busy;
  logic        rd_en;
  logic [9:0]  index_rd;
  logic [15:0] data_rd = '0;

  always #5 clk = ~clk;

  table_rd_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mask(rsp_mask), .rsp_last(rsp_last),
    .scan_start(scan_start), .scan_busy(scan_busy),
    .rd_en(rd_en), .index_rd(index_rd), .data_rd(data_rd)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mask;
    logic        last;
  } beat_t;

  beat_t       q[$];
  logic [7:0]  mem [TS];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  bit          last_acc = 0;
  bit          saw_last = 0;
  bit          stall_prev = 0;
  beat_t       prev_beat;

  // behavioural table: one-cycle registered read
  always @(posedge clk)
    if (rd_en) data_rd <= {mem[index_rd[9:5]], mem[index_rd[4:0]]};

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor: pops the scoreboard on every accepted response beat
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid) begin
      if (stall_prev)
        chk("rsp_stable", {rsp_data, rsp_mask, rsp_last}, prev_beat);
      if (rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {rsp_data, rsp_mask, rsp_last}, 0);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_mask", rsp_mask, e.mask);
          chk("rsp_last", rsp_last, e.last);
          if (e.last) saw_last = 1;
        end
        pop_cnt++;
      end
      stall_prev = !rsp_ready;
      prev_beat  = {rsp_data, rsp_mask, rsp_last};
    end else begin
      stall_prev = 0;
    end
  end

  // one clock of stimulus; in plain mode the credit rule predicts req_ready
  task automatic cyc(input bit v, input logic [9:0] idx, input bit rr,
                     input bit ss, input bit scan_mode);
    int landed;
    int pop_now;
    bit acc;
    @(negedge clk);
    req_valid  = v;
    req_index  = idx;
    rsp_ready  = rr;
    scan_start = ss;
    #1;
    acc = 0;
    if (scan_mode) begin
      chk("req_ready_scan", req_ready, 0);
    end else begin
      landed  = acc_cnt - pop_cnt - int'(last_acc);
      pop_now = (rr && landed > 0) ? 1 : 0;
      chk("rsp_valid", rsp_valid, landed > 0);
      chk("req_ready", req_ready, ((acc_cnt - pop_cnt - pop_now) < 2) && !ss);
      if (v && req_ready) begin
        q.push_back({mem[idx[9:5]], mem[idx[4:0]], 2'b11, 1'b0});
        acc = 1;
      end
    end
    acc_cnt += int'(acc);
    last_acc = acc;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++)
      cyc(0, '0, 1, 0, 0);
    chk("drain_left", q.size(), 0);
    cyc(0, '0, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1;
    req_valid  = 1;
    req_index  = 10'h3ff;
    rsp_ready  = 0;
    scan_start = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_index_rd", index_rd, 0);
    @(negedge clk);
    rst       = 0;
    req_valid = 0;
    req_index = '0;
    #1;
    q.delete();
    acc_cnt  = pop_cnt;
    last_acc = 0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_scan_busy", scan_busy, 0);
`ifdef TABLE_RD_SCAN_EN
    chk("rst_rsp_mask", rsp_mask, 2'b00);
    chk("rst_rsp_last", rsp_last, 0);
`else
    chk("rsp_mask_tied", rsp_mask, 2'b11);
`endif
  endtask

  task automatic send_seq(input logic [9:0] idx [8], input bit stall);
    int sent;
    int n;
    bit rr;
    sent = 0;
    n    = 0;
    while (sent < 8 && n < 100) begin
      rr = !(stall && n >= 3 && n < 8);
      cyc(1, idx[sent], rr, 0, 0);
      if (last_acc) sent++;
      n++;
    end
    chk("seq_sent", sent, 8);
    drain();
  endtask

`ifdef TABLE_RD_SCAN_EN
  logic        rsp_valid5;
  logic        req_ready5;
  logic [15:0] rsp_data5;
  logic [1:0]  rsp_mask5;
  logic        rsp_last5;
  logic        scan_start5 = 1'b0;
  logic        scan_busy5;
  logic        rd_en5;
  logic [5:0]  index_rd5;
  logic [15:0] data_rd5 = '0;

  table_rd_ctrl #(.TABLE_SIZE(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .req_valid(1'b0), .req_ready(req_ready5), .req_index(6'd0),
    .rsp_valid(rsp_valid5), .rsp_ready(1'b1), .rsp_data(rsp_data5),
    .rsp_mask(rsp_mask5), .rsp_last(rsp_last5),
    .scan_start(scan_start5), .scan_busy(scan_busy5),
    .rd_en(rd_en5), .index_rd(index_rd5), .data_rd(data_rd5)
  );

  always @(posedge clk)
    if (rd_en5)
      data_rd5 <= {8'h40 + 8'(index_rd5[5:3]), 8'h40 + 8'(index_rd5[2:0])};

  task automatic scan_test();
    bit done;
    bit pend;
    for (int i = 0; i < TS; i++) mem[i] = 8'h40 + 8'(i);
    saw_last = 0;
    cyc(1, 10'($urandom), 1, 1, 0);
    for (int k = 0; k < 16; k++)
      q.push_back({8'h40 + 8'(2*k+1), 8'h40 + 8'(2*k), 2'b11, k == 15});
    acc_cnt  = pop_cnt;
    last_acc = 0;
    done     = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      pend = saw_last;
      if (pend) begin
        acc_cnt  = pop_cnt;
        last_acc = 0;
        cyc(0, '0, 1, 0, 0);
        chk("scan_busy_end", scan_busy, 0);
        done = 1;
      end else begin
        cyc(1, 10'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1);
        chk("scan_busy", scan_busy, 1);
      end
    end
    chk("scan_done", done, 1);
    chk("scan_left", q.size(), 0);
  endtask

  task automatic scan5_test();
    int k;
    bit fin;
    k   = 0;
    fin = 0;
    @(negedge clk);
    scan_start5 = 1;
    @(negedge clk);
    scan_start5 = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid5) begin
        chk("ts5_lane0", rsp_data5[7:0], 8'h40 + 8'(2*k));
        if (2*k + 1 < 5)
          chk("ts5_lane1", rsp_data5[15:8], 8'h40 + 8'(2*k+1));
        chk("ts5_mask", rsp_mask5, (2*k + 1 < 5) ? 2'b11 : 2'b01);
        chk("ts5_last", rsp_last5, k == 2);
        fin = rsp_last5;
        k++;
      end
    end
    chk("ts5_beats", k, 3);
  endtask
`endif

  initial begin
    logic [9:0] seq [8];
    for (int i = 0; i < TS; i++) mem[i] = 8'($urandom);
    mem[3]  = 8'hA5;
    mem[17] = 8'h3C;
    do_reset();

    cyc(1, {5'd17, 5'd3}, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("preload_data", rsp_data, 16'h3CA5);
    chk("preload_mask", rsp_mask, 2'b11);
    drain();

    for (int i = 0; i < 8; i++) seq[i] = 10'($urandom);
    send_seq(seq, 0);
    send_seq(seq, 1);

    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 3) != 0), 10'($urandom),
          ($urandom_range(0, 3) != 0), 0, 0);
    drain();

`ifdef TABLE_RD_SCAN_EN
    scan_test();
    scan5_test();

    cyc(0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0, 1);
    chk("midscan_buffered", rsp_valid, 1);
    do_reset();
    cyc(1, {5'd9, 5'd5}, 1, 0, 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
